// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: data widths, the canonical NOP,
// fetch FSM state encoding and the instruction-buffer entry layout.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_STALL,
        S_ERR
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// In-order instruction buffer of {instr, pc} entries between fetch and decode.
// Flush beats push and pop; the head entry is read combinationally.
module fetch_buffer
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           push_entry,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          empty;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign do_pop  = pop && !empty;
    // A full buffer can still take a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (PW + 1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (PW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_entry;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one-at-a-time word fetches over
// req/gnt/rvalid, buffers responses and hands them to decode with valid/ready.
module if_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] Instr_rdata,
    output logic [XLEN-1:0] instr_pc,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            fetch_err
);

    localparam int              CW       = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW-1:0]   DEPTH_C  = CW'(BUF_DEPTH);
    localparam logic [XLEN-1:0] START_PC = {RESET_PC[XLEN-1:2], 2'b00};

    fetch_state_t    state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_pc;
    logic            outstanding;
    logic            drop;

    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    fetch_entry_t    head;
    fetch_entry_t    push_entry;
    logic            push;
    logic            pop;
    logic            flush;
    logic            gnt_taken;
    logic            resp;
    logic            resp_pending;
    logic            credit_ok;
    logic            redirect_bad;

    assign imem_addr    = fetch_pc;
    assign gnt_taken    = imem_req && imem_gnt;
    assign resp         = imem_rvalid && outstanding;
    // A response is still owed after this cycle if one was in flight and did not
    // return now, or if a new request is granted now.
    assign resp_pending = (outstanding && !imem_rvalid) || gnt_taken;
    assign redirect_bad = redirect_en && !is_word_aligned(redirect_pc);

    assign flush        = redirect_en;
    assign push         = resp && !drop && (state != S_ERR);
    assign pop          = instr_valid && instr_ready;
    assign push_entry   = '{instr: imem_rdata, pc: req_pc};

    assign instr_valid  = (count != '0);
    assign Instr_rdata  = instr_valid ? head.instr : NOP_INSTR;
    assign instr_pc     = instr_valid ? head.pc    : RESET_PC;

    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (pop && !push) begin
            count_next = count - CW'(1);
        end
    end

    assign credit_ok = (count_next < DEPTH_C);

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_fetch_buffer (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push),
        .pop        (pop),
        .flush      (flush),
        .push_entry (push_entry),
        .head       (head),
        .count      (count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            fetch_pc    <= START_PC;
            req_pc      <= START_PC;
            outstanding <= 1'b0;
            drop        <= 1'b0;
            imem_req    <= 1'b0;
            fetch_err   <= 1'b0;
        end else begin
            if (gnt_taken) begin
                req_pc <= fetch_pc;
            end

            if (state == S_ERR) begin
                imem_req <= 1'b0;
                if (imem_rvalid) begin
                    outstanding <= 1'b0;
                    drop        <= 1'b0;
                end
            end else if (redirect_bad) begin
                fetch_err   <= 1'b1;
                state       <= S_ERR;
                imem_req    <= 1'b0;
                outstanding <= resp_pending;
                drop        <= resp_pending;
            end else if (redirect_en) begin
                fetch_pc <= redirect_pc;
                // Park in S_WAIT until the stale response has been swallowed.
                if (resp_pending) begin
                    outstanding <= 1'b1;
                    drop        <= 1'b1;
                    state       <= S_WAIT;
                    imem_req    <= 1'b0;
                end else begin
                    outstanding <= 1'b0;
                    drop        <= 1'b0;
                    state       <= S_REQ;
                    imem_req    <= 1'b1;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        state    <= S_REQ;
                        imem_req <= 1'b1;
                    end
                    S_REQ: begin
                        if (imem_gnt) begin
                            fetch_pc    <= fetch_pc + 32'd4;
                            outstanding <= 1'b1;
                            state       <= S_WAIT;
                            imem_req    <= 1'b0;
                        end
                    end
                    S_WAIT: begin
                        if (resp) begin
                            outstanding <= 1'b0;
                            drop        <= 1'b0;
                            if (credit_ok) begin
                                state    <= S_REQ;
                                imem_req <= 1'b1;
                            end else begin
                                state    <= S_STALL;
                                imem_req <= 1'b0;
                            end
                        end
                    end
                    S_STALL: begin
                        if (credit_ok) begin
                            state    <= S_REQ;
                            imem_req <= 1'b1;
                        end
                    end
                    default: begin
                        state    <= S_ERR;
                        imem_req <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Memory must never return data for a request this unit did not have in flight.
    assert property (@(posedge clk) disable iff (!reset_n) imem_rvalid |-> outstanding);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with an in-order memory responder whose grant
// and response delays are adjustable; memory returns 32'h1000_0000 + address.
module tb_if_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] Instr_rdata;
    logic [31:0] instr_pc;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        fetch_err;

    int compared   = 0;
    int mismatched = 0;

    int          gnt_delay = 0;
    int          rsp_delay = 0;
    int          gnt_wait  = 0;
    int          rsp_wait  = 0;
    logic        rsp_pending = 1'b0;
    logic [31:0] rsp_addr    = 32'h0;

    if_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .Instr_rdata (Instr_rdata),
        .instr_pc    (instr_pc),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .fetch_err   (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: acts on falling edges so the DUT samples stable inputs.
    initial begin
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            imem_rvalid = 1'b0;
            if (rsp_pending) begin
                if (rsp_wait == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = 32'h1000_0000 + rsp_addr;
                    rsp_pending = 1'b0;
                end else begin
                    rsp_wait = rsp_wait - 1;
                end
            end
            imem_gnt = 1'b0;
            if (imem_req && reset_n) begin
                if (gnt_wait >= gnt_delay) begin
                    imem_gnt    = 1'b1;
                    gnt_wait    = 0;
                    rsp_pending = 1'b1;
                    rsp_addr    = imem_addr;
                    rsp_wait    = rsp_delay;
                end else begin
                    gnt_wait = gnt_wait + 1;
                end
            end else begin
                gnt_wait = 0;
            end
        end
    end

    task automatic applyStimulus(input logic rst_v, input logic ready_v,
                                 input logic ren_v, input logic [31:0] rpc_v);
        reset_n     = rst_v;
        instr_ready = ready_v;
        redirect_en = ren_v;
        redirect_pc = rpc_v;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n     = 1'b0;
        instr_ready = 1'b1;
        redirect_en = 1'b0;
        redirect_pc = 32'h0;

        // Reset state
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("rst_req",   32'(imem_req),    32'd0);
        checkOutput("rst_valid", 32'(instr_valid), 32'd0);
        checkOutput("rst_rdata", Instr_rdata,      32'h0000_0013);
        checkOutput("rst_pc",    instr_pc,         32'h0);
        checkOutput("rst_err",   32'(fetch_err),   32'd0);

        // Plan 1: immediate grant, 1-cycle response, decode always ready
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("t1_req0",   32'(imem_req),    32'd1);
        checkOutput("t1_addr0",  imem_addr,        32'h0);
        checkOutput("t1_val_c1", 32'(instr_valid), 32'd0);
        checkOutput("t1_nop_c1", Instr_rdata,      32'h0000_0013);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("t1_req_c2", 32'(imem_req),    32'd0);
        checkOutput("t1_val_c2", 32'(instr_valid), 32'd0);
        checkOutput("t1_nop_c2", Instr_rdata,      32'h0000_0013);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("t1_val_c3", 32'(instr_valid), 32'd1);
        checkOutput("t1_pc_c3",  instr_pc,         32'h0);
        checkOutput("t1_dat_c3", Instr_rdata,      32'h1000_0000);
        checkOutput("t1_req4",   32'(imem_req),    32'd1);
        checkOutput("t1_addr4",  imem_addr,        32'h4);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("t1_val_c4", 32'(instr_valid), 32'd0);
        checkOutput("t1_req_c4", 32'(imem_req),    32'd0);
        rsp_delay = 2;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("t1_val_c5", 32'(instr_valid), 32'd1);
        checkOutput("t1_pc_c5",  instr_pc,         32'h4);
        checkOutput("t1_dat_c5", Instr_rdata,      32'h1000_0004);
        checkOutput("t1_addr8",  imem_addr,        32'h8);

        // Plan 3: redirect while the fetch of 0x8 is in flight
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("t3_req_w",  32'(imem_req),    32'd0);
        checkOutput("t3_val_w",  32'(instr_valid), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h100);
        checkOutput("t3_req_r",  32'(imem_req),    32'd0);
        checkOutput("t3_val_r",  32'(instr_valid), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("t3_val_d",  32'(instr_valid), 32'd0);
        rsp_delay = 0;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("t3_val_x",  32'(instr_valid), 32'd0);
        checkOutput("t3_req100", 32'(imem_req),    32'd1);
        checkOutput("t3_adr100", imem_addr,        32'h100);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("t3_val_y",  32'(instr_valid), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("t3_val100", 32'(instr_valid), 32'd1);
        checkOutput("t3_pc100",  instr_pc,         32'h100);
        checkOutput("t3_dat100", Instr_rdata,      32'h1000_0100);

        // Plan 4: fill the buffer, then redirect in the same cycle as a pop
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("t4_full_v", 32'(instr_valid), 32'd1);
        checkOutput("t4_full_pc", instr_pc,        32'h100);
        checkOutput("t4_stall",  32'(imem_req),    32'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h200);
        checkOutput("t4_flush_v", 32'(instr_valid), 32'd0);
        checkOutput("t4_flush_d", Instr_rdata,     32'h0000_0013);
        checkOutput("t4_flush_pc", instr_pc,       32'h0);
        checkOutput("t4_req200", 32'(imem_req),    32'd1);
        checkOutput("t4_adr200", imem_addr,        32'h200);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("t4_val200", 32'(instr_valid), 32'd1);
        checkOutput("t4_pc200",  instr_pc,         32'h200);
        checkOutput("t4_dat200", Instr_rdata,      32'h1000_0200);

        // Plan 2: from a fresh reset with decode stalled
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("t2_rst_v",  32'(instr_valid), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("t2_one_pc", instr_pc,         32'h0);
        checkOutput("t2_addr4",  imem_addr,        32'h4);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
            checkOutput("t2_stall_req", 32'(imem_req), 32'd0);
            checkOutput("t2_stall_pc",  instr_pc,      32'h0);
        end
        checkOutput("t2_stall_d", Instr_rdata,     32'h1000_0000);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("t2_pop1_req", 32'(imem_req),  32'd1);
        checkOutput("t2_pop1_adr", imem_addr,      32'h8);
        checkOutput("t2_pop1_pc",  instr_pc,       32'h4);
        checkOutput("t2_pop1_d",   Instr_rdata,    32'h1000_0004);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("t2_pop2_v",   32'(instr_valid), 32'd0);
        checkOutput("t2_pop2_req", 32'(imem_req),  32'd0);
        gnt_delay = 5;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("t2_pc8",    instr_pc,         32'h8);
        checkOutput("t2_req_c",  32'(imem_req),    32'd1);
        checkOutput("t2_adr_c",  imem_addr,        32'hC);

        // Plan 5: grant held off for 5 cycles, redirect in the middle
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("t5_req_a",  32'(imem_req),    32'd1);
        checkOutput("t5_adr_a",  imem_addr,        32'hC);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("t5_req_b",  32'(imem_req),    32'd1);
        checkOutput("t5_adr_b",  imem_addr,        32'hC);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h300);
        checkOutput("t5_req_c",  32'(imem_req),    32'd1);
        checkOutput("t5_adr_c",  imem_addr,        32'h300);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("t5_req_d",  32'(imem_req),    32'd1);
        checkOutput("t5_adr_d",  imem_addr,        32'h300);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("t5_req_e",  32'(imem_req),    32'd1);
        checkOutput("t5_adr_e",  imem_addr,        32'h300);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("t5_req_f",  32'(imem_req),    32'd0);
        gnt_delay = 0;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("t5_val300", 32'(instr_valid), 32'd1);
        checkOutput("t5_pc300",  instr_pc,         32'h300);
        checkOutput("t5_dat300", Instr_rdata,      32'h1000_0300);

        // Plan 6: misaligned redirect is fatal until reset
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h102);
        checkOutput("t6_err",    32'(fetch_err),   32'd1);
        checkOutput("t6_req",    32'(imem_req),    32'd0);
        checkOutput("t6_val",    32'(instr_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
            checkOutput("t6_err_hold", 32'(fetch_err), 32'd1);
            checkOutput("t6_req_hold", 32'(imem_req),  32'd0);
            checkOutput("t6_val_hold", 32'(instr_valid), 32'd0);
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h400);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("t6_err_redir", 32'(fetch_err), 32'd1);
        checkOutput("t6_req_redir", 32'(imem_req),  32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("t6_rst_err", 32'(fetch_err),  32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("t6_req0",   32'(imem_req),    32'd1);
        checkOutput("t6_adr0",   imem_addr,        32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("t6_val0",   32'(instr_valid), 32'd1);
        checkOutput("t6_pc0",    instr_pc,         32'h0);
        checkOutput("t6_dat0",   Instr_rdata,      32'h1000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the instruction decoder.
- Owns the PC register and issues word requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned words in a small in-order buffer and presents Instr_rdata plus its PC to decode with a valid/ready handshake.
- Accepts redirects from the branch/jump unit and flushes stale fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC of first fetch after reset; must be word-aligned.
BUF_DEPTH, 2, instruction buffer entries; power of two, >= 2.

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous, active-low reset.
imem_req  output  1  fetch request valid.
imem_addr  output  32  fetch word address; bits [1:0] always 0.
imem_gnt  input  1  memory accepted request this cycle.
imem_rvalid  input  1  read data valid; responses arrive in order, at least 1 cycle after gnt.
imem_rdata  input  32  read data.
instr_valid  output  1  Instr_rdata/instr_pc hold a fetched instruction.
instr_ready  input  1  decode consumes the head entry this cycle.
Instr_rdata  output  32  head instruction; 32'h0000_0013 (NOP) when buffer empty.
instr_pc  output  32  PC of head instruction; RESET_PC when empty.
redirect_en  input  1  take redirect this cycle.
redirect_pc  input  32  new fetch PC.
fetch_err  output  1  sticky misaligned-redirect error.

Behaviour:
- Reset (async assert, sync release): state S_IDLE, fetch_pc=RESET_PC, buffer empty, outstanding=0, drop=0, imem_req=0, instr_valid=0, fetch_err=0, Instr_rdata=NOP.
- Credit rule: a request may be issued only when count + outstanding < BUF_DEPTH; at most one request is outstanding.
- FSM states and transitions:
  - S_IDLE: one cycle after reset release, then S_REQ.
  - S_REQ: imem_req=1, imem_addr=fetch_pc. On gnt, fetch_pc += 4 (wraps 32'hFFFF_FFFC -> 0), outstanding=1, go to S_WAIT.
  - S_WAIT: imem_req=0. On rvalid, push {imem_rdata, pc_of_request} unless drop=1; clear outstanding and drop. Next state is S_REQ if credit allows, else S_STALL.
  - S_STALL: imem_req=0. Go to S_REQ when credit frees. A pop frees credit in the same cycle, so req rises on the next cycle.
  - S_ERR: imem_req=0, instr_valid=0, buffer empty. Exit only by reset.
- Request stability: while imem_req=1 without gnt, imem_addr is held stable, except that a redirect updates it the next cycle while req stays high.
- Output: instr_valid = (count != 0). Pop on instr_valid && instr_ready. Push and pop in the same cycle leave count unchanged. Data is combinational from the head entry (zero added latency once buffered).
- Latency: with gnt in the req cycle and rvalid one cycle later, the first instr_valid occurs 3 cycles after reset release. Steady-state throughput is 1 instruction per 2 cycles with one outstanding request. Memory stalls insert bubbles only.
- Redirect (redirect_en=1, redirect_pc[1:0]==0):
  - In the same cycle the buffer is flushed (count=0) and fetch_pc <= redirect_pc.
  - If a request is outstanding, or gnt occurs this cycle, drop <= 1 so the next rvalid is discarded.
  - Next state is S_REQ, or S_WAIT while a dropped response is pending, then S_REQ.
  - Redirect wins over a simultaneous pop or push: the popped or pushed entry is discarded, and instr_valid is 0 on the following cycle.
- Misaligned redirect (redirect_pc[1:0]!=0): fetch_err <= 1, flush, go to S_ERR. Any pending response is dropped.
- Redirect to the same address as fetch_pc still flushes; no special case.
- Undefined conditions:
  - rvalid with no outstanding request: ignored, and flagged by an assertion.
  - gnt while imem_req=0: ignored.

Decomposition:
- riscv_pkg (shared) holds:
  - NOP_INSTR = 32'h0000_0013
  - fetch_state_t enum {S_IDLE, S_REQ, S_WAIT, S_STALL, S_ERR}
  - XLEN = 32
- Sub-module fetch_buffer: a BUF_DEPTH-entry FIFO of {instr, pc} with push, pop, flush, count, and head outputs; flush has priority over push and pop.
- The FSM, PC, and drop logic live in if_fetch_unit.

Test Plan:
1. Reset release, memory grants immediately and returns rvalid 1 cycle later, instr_ready=1 -> imem_addr 0x0, 0x4, 0x8 in order; first instr_valid on cycle 3 with instr_pc=0x0 and Instr_rdata equal to the returned word; before that Instr_rdata=0x00000013.
2. instr_ready=0 for 10 cycles -> buffer fills to 2 entries; imem_req stays 0 in S_STALL. Raise ready -> entries pop in PC order 0x0, 0x4; imem_req rises the cycle after the first pop.
3. Redirect to 0x100 while a request to 0x8 is outstanding -> the 0x8 response is dropped and the next instr_pc is 0x100; no instruction from 0x8 ever has instr_valid=1.
4. Redirect in the same cycle as a pop with 2 entries buffered -> count=0 next cycle; the next instructions come from redirect_pc.
5. gnt delayed 5 cycles -> imem_req and imem_addr are held stable throughout; a redirect mid-wait changes imem_addr next cycle with req still high.
6. redirect_pc=0x102 -> fetch_err=1 next cycle and stays high; imem_req=0 and instr_valid=0 until reset_n is asserted; after reset, fetch resumes from RESET_PC.
